pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and bubble-insert (flush) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branch/jump redirects resolved in MEM, multi-cycle data/instruction memory stalls, and the halt (dump) drain.
- Counts stall cycles and detects data-memory timeouts.

---
 rtl/pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Drives the enable and bubble-insert controls of the PC and the four
// pipeline registers. It resolves the following conditions:
//   - load-use hazards
//   - redirects resolved in MEM
//   - multi-cycle instruction and data memory stalls
//   - the halt drain
// It also keeps a saturating stall-cycle counter and a sticky flag that is
// set when a data-memory access times out.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 31,  // legal range 1..255
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,               // asynchronous, active-low
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [2:0]       idex_reg_wr_sel,
  input  logic             idex_mem_to_reg,
  input  logic             exmem_branch_cond,
  input  logic             exmem_mem_access,
  input  logic             exmem_dump,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             imem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DWAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } fl_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t           state;
  logic [8:0]       wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic dstall;
  logic load_use;
  logic run_drain;
  logic count_stall;
  logic timeout;
  en_t  run_en;
  fl_t  run_fl;
  en_t  cur_en;
  fl_t  cur_fl;

  // A data access that is still busy this cycle freezes the front of the pipe.
  assign dstall   = exmem_mem_access & dmem_stall & ~dmem_done;

  // Register 0 is deliberately not special-cased; a match on r0 also stalls.
  assign load_use = idex_mem_to_reg &
                    ((id_uses_rs & (id_rs == idex_reg_wr_sel)) |
                     (id_uses_rt & (id_rt == idex_reg_wr_sel)));

  // The next wait count would hit the limit, so this DWAIT cycle gives up.
  assign timeout  = (wait_cnt + 9'd1) >= TIMEOUT_LIM;

  // Normal-flow priority chain: redirect, halt, load-use, imem stall, run.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    run_en    = '1;
    run_fl    = '0;
    run_drain = 1'b0;
    if (exmem_branch_cond) begin
      run_fl.ifid  = 1'b1;
      run_fl.idex  = 1'b1;
      run_fl.exmem = 1'b1;
    end else if (exmem_dump) begin
      run_fl.ifid  = 1'b1;
      run_fl.idex  = 1'b1;
      run_fl.exmem = 1'b1;
      run_drain    = 1'b1;
    end else if (load_use) begin
      run_en.pc   = 1'b0;
      run_en.ifid = 1'b0;
      run_fl.idex = 1'b1;
    end else if (imem_stall) begin
      run_en.pc   = 1'b0;
      run_fl.ifid = 1'b1;
    end
  end

  // Per-state selection of the register controls presented this cycle.
  always_comb begin
    cur_en = '0;
    cur_fl = '0;
    case (state)
      S_RUN: begin
        if (dstall) begin
          cur_en.memwb = 1'b1;
          cur_fl.memwb = 1'b1;
        end else begin
          cur_en = run_en;
          cur_fl = run_fl;
        end
      end
      S_DWAIT: begin
        // The completing cycle behaves like RUN so the MEM result is captured
        // and any redirect or halt held in the frozen EX/MEM takes effect.
        if (dmem_done) begin
          cur_en = run_en;
          cur_fl = run_fl;
        end else begin
          cur_en.memwb = 1'b1;
          cur_fl.memwb = 1'b1;
        end
      end
      S_DRAIN: begin
        // Only MEM/WB advances, carrying the halt instruction into WB.
        cur_en.memwb = 1'b1;
      end
      default: begin
        // HALT: everything stays frozen until reset.
      end
    endcase
  end

  assign count_stall = ~cur_en.pc & (state != S_HALT);

  // State, wait counter, sticky error and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (count_stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state)
        S_RUN: begin
          if (dstall) begin
            state    <= S_DWAIT;
            wait_cnt <= 9'd1;
          end else if (run_drain) begin
            state <= S_DRAIN;
          end
        end
        S_DWAIT: begin
          if (dmem_done) begin
            state    <= run_drain ? S_DRAIN : S_RUN;
            wait_cnt <= '0;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 9'd1;
          end
        end
        S_DRAIN: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

  // Controls are forced inactive for as long as reset is held.
  assign pc_en       = rst & cur_en.pc;
  assign ifid_en     = rst & cur_en.ifid;
  assign idex_en     = rst & cur_en.idex;
  assign exmem_en    = rst & cur_en.exmem;
  assign memwb_en    = rst & cur_en.memwb;
  assign ifid_flush  = rst & cur_fl.ifid;
  assign idex_flush  = rst & cur_fl.idex;
  assign exmem_flush = rst & cur_fl.exmem;
  assign memwb_flush = rst & cur_fl.memwb;
  assign halted      = rst & (state == S_HALT);
  assign err         = err_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Two instances share the stimulus:
// dut_a with default parameters, and dut_b with a short timeout and a narrow
// counter so that the timeout and saturation boundaries are exercised.
module tb_pipe_hazard_ctrl;

  localparam int TMO_A = 31;
  localparam int CW_A  = 16;
  localparam int TMO_B = 3;
  localparam int CW_B  = 4;

  localparam int M_RUN   = 0;
  localparam int M_DWAIT = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] id_rs, id_rt, idex_reg_wr_sel;
  logic       id_uses_rs, id_uses_rt, idex_mem_to_reg;
  logic       exmem_branch_cond, exmem_mem_access, exmem_dump;
  logic       dmem_stall, dmem_done, imem_stall;

  logic pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
  logic ifid_fl_a, idex_fl_a, exmem_fl_a, memwb_fl_a, halted_a, err_a;
  logic [CW_A-1:0] cnt_a;
  logic pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
  logic ifid_fl_b, idex_fl_b, exmem_fl_b, memwb_fl_b, halted_b, err_b;
  logic [CW_B-1:0] cnt_b;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_reg_wr_sel(idex_reg_wr_sel), .idex_mem_to_reg(idex_mem_to_reg),
    .exmem_branch_cond(exmem_branch_cond), .exmem_mem_access(exmem_mem_access),
    .exmem_dump(exmem_dump), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .imem_stall(imem_stall),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .exmem_en(exmem_en_a),
    .memwb_en(memwb_en_a), .ifid_flush(ifid_fl_a), .idex_flush(idex_fl_a),
    .exmem_flush(exmem_fl_a), .memwb_flush(memwb_fl_a), .halted(halted_a),
    .err(err_a), .stall_count(cnt_a)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_reg_wr_sel(idex_reg_wr_sel), .idex_mem_to_reg(idex_mem_to_reg),
    .exmem_branch_cond(exmem_branch_cond), .exmem_mem_access(exmem_mem_access),
    .exmem_dump(exmem_dump), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .imem_stall(imem_stall),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .exmem_en(exmem_en_b),
    .memwb_en(memwb_en_b), .ifid_flush(ifid_fl_b), .idex_flush(idex_fl_b),
    .exmem_flush(exmem_fl_b), .memwb_flush(memwb_fl_b), .halted(halted_b),
    .err(err_b), .stall_count(cnt_b)
  );

  typedef struct {
    bit       rst;
    bit [2:0] rs, rt, wsel;
    bit       urs, urt, m2r, br, macc, dump, dstall, ddone, istall;
  } stim_t;

  // en bits: {pc, ifid, idex, exmem, memwb}; fl bits: {ifid, idex, exmem, memwb}
  typedef struct {
    bit [4:0] en;
    bit [3:0] fl;
    bit       halted;
    bit       err;
    int       cnt;
  } exp_t;

  typedef struct {
    int st;
    int wt;
    bit err;
    int cnt;
  } mdl_t;

  typedef struct {
    exp_t a;
    exp_t b;
    int   cyc;
  } pair_t;

  pair_t sb[$];
  mdl_t  ma, mb;
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    mon_cyc = 0;

  // Reference model: one pipeline cycle computed from the sequencing rules.
  function automatic void model(inout mdl_t m, input stim_t s, input int tmo,
                                input int cmax, output exp_t e);
    bit dst, lu, go_drain;
    int old_st;
    e = '{en: 5'b0, fl: 4'b0, halted: 1'b0, err: 1'b0, cnt: 0};
    if (!s.rst) begin
      m = '{st: M_RUN, wt: 0, err: 1'b0, cnt: 0};
      return;
    end
    old_st   = m.st;
    e.err    = m.err;
    e.cnt    = m.cnt;
    e.halted = (m.st == M_HALT);
    dst      = s.macc && s.dstall && !s.ddone;
    lu       = s.m2r && ((s.urs && s.rs == s.wsel) || (s.urt && s.rt == s.wsel));
    go_drain = 1'b0;
    // Normal-flow outcome, used in RUN and on the completing DWAIT cycle.
    if (s.br)          begin e.en = 5'b11111; e.fl = 4'b1110; end
    else if (s.dump)   begin e.en = 5'b11111; e.fl = 4'b1110; go_drain = 1'b1; end
    else if (lu)       begin e.en = 5'b00111; e.fl = 4'b0100; end
    else if (s.istall) begin e.en = 5'b01111; e.fl = 4'b1000; end
    else               begin e.en = 5'b11111; e.fl = 4'b0000; end
    case (m.st)
      M_RUN: begin
        if (dst) begin
          e.en = 5'b00001; e.fl = 4'b0001;
          m.st = M_DWAIT; m.wt = 1;
        end else if (go_drain) begin
          m.st = M_DRAIN;
        end
      end
      M_DWAIT: begin
        if (s.ddone) begin
          m.st = go_drain ? M_DRAIN : M_RUN;
          m.wt = 0;
        end else begin
          e.en = 5'b00001; e.fl = 4'b0001;
          m.wt = m.wt + 1;
          if (m.wt >= tmo) begin
            m.err = 1'b1;
            m.st  = M_HALT;
          end
        end
      end
      M_DRAIN: begin
        e.en = 5'b00001; e.fl = 4'b0000;
        m.st = M_HALT;
      end
      default: begin
        e.en = 5'b00000; e.fl = 4'b0000;
      end
    endcase
    if (!e.en[4] && old_st != M_HALT && m.cnt < cmax) m.cnt = m.cnt + 1;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, mon_cyc, act, exp);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge and queues the expectation.
  task automatic drive(input stim_t s);
    pair_t p;
    @(negedge clk);
    rst               = s.rst;
    id_rs             = s.rs;
    id_rt             = s.rt;
    id_uses_rs        = s.urs;
    id_uses_rt        = s.urt;
    idex_reg_wr_sel   = s.wsel;
    idex_mem_to_reg   = s.m2r;
    exmem_branch_cond = s.br;
    exmem_mem_access  = s.macc;
    exmem_dump        = s.dump;
    dmem_stall        = s.dstall;
    dmem_done         = s.ddone;
    imem_stall        = s.istall;
    model(ma, s, TMO_A, (1 << CW_A) - 1, p.a);
    model(mb, s, TMO_B, (1 << CW_B) - 1, p.b);
    p.cyc = cyc;
    cyc++;
    sb.push_back(p);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, rs: 3'd0, rt: 3'd0, wsel: 3'd0, urs: 1'b0, urt: 1'b0, m2r: 1'b0,
          br: 1'b0, macc: 1'b0, dump: 1'b0, dstall: 1'b0, ddone: 1'b0, istall: 1'b0};
    return s;
  endfunction

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    drive(s);
    drive(s);
    drive(idle());
  endtask

  // Monitor: compares every presented output set against the queued expectation.
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        p = sb.pop_front();
        mon_cyc = p.cyc;
        check("a_en", {pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a}, p.a.en);
        check("a_flush", {ifid_fl_a, idex_fl_a, exmem_fl_a, memwb_fl_a}, p.a.fl);
        check("a_halted", halted_a, p.a.halted);
        check("a_err", err_a, p.a.err);
        check("a_stall_count", cnt_a, p.a.cnt);
        check("b_en", {pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b}, p.b.en);
        check("b_flush", {ifid_fl_b, idex_fl_b, exmem_fl_b, memwb_fl_b}, p.b.fl);
        check("b_halted", halted_b, p.b.halted);
        check("b_err", err_b, p.b.err);
        check("b_stall_count", cnt_b, p.b.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    rst = 1'b0;
    {id_rs, id_rt, idex_reg_wr_sel} = '0;
    {id_uses_rs, id_uses_rt, idex_mem_to_reg} = '0;
    {exmem_branch_cond, exmem_mem_access, exmem_dump} = '0;
    {dmem_stall, dmem_done, imem_stall} = '0;
    ma = '{st: M_RUN, wt: 0, err: 1'b0, cnt: 0};
    mb = '{st: M_RUN, wt: 0, err: 1'b0, cnt: 0};
    do_reset();

    // Load-use on rs, then on r0 through rt.
    s = idle(); s.m2r = 1; s.wsel = 3'd3; s.rs = 3'd3; s.urs = 1;
    drive(s);
    drive(idle());
    s = idle(); s.m2r = 1; s.wsel = 3'd0; s.rt = 3'd0; s.urt = 1;
    drive(s);
    s = idle(); s.m2r = 1; s.wsel = 3'd5; s.rs = 3'd5; s.urs = 0;
    drive(s);
    drive(idle());

    // Redirect beats imem stall and load-use.
    s = idle(); s.br = 1; s.istall = 1; s.m2r = 1; s.wsel = 3'd2; s.rs = 3'd2; s.urs = 1;
    drive(s);
    s = idle(); s.istall = 1;
    drive(s);
    drive(idle());

    // Store stalls four cycles and completes on the fifth.
    do_reset();
    s = idle(); s.macc = 1; s.dstall = 1;
    repeat (4) drive(s);
    s = idle(); s.macc = 1; s.ddone = 1;
    drive(s);
    drive(idle());
    drive(idle());

    // Branch held behind a two-cycle dmem stall.
    do_reset();
    s = idle(); s.br = 1; s.macc = 1; s.dstall = 1;
    repeat (2) drive(s);
    s = idle(); s.br = 1; s.macc = 1; s.ddone = 1;
    drive(s);
    drive(idle());

    // Halt: drain, then halted for a long stretch.
    do_reset();
    s = idle(); s.dump = 1;
    drive(s);
    repeat (12) drive(idle());

    // Timeout on dut_b; reset asserted mid-DWAIT on dut_a.
    do_reset();
    s = idle(); s.macc = 1; s.dstall = 1;
    repeat (5) drive(s);
    do_reset();

    // Counter saturation on the narrow counter.
    s = idle(); s.istall = 1;
    repeat (20) drive(s);
    drive(idle());

    // Randomised traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 79) != 0);
      s.rs     = 3'($urandom_range(0, 7));
      s.rt     = 3'($urandom_range(0, 7));
      s.wsel   = 3'($urandom_range(0, 7));
      s.urs    = ($urandom_range(0, 1) == 1);
      s.urt    = ($urandom_range(0, 1) == 1);
      s.m2r    = ($urandom_range(0, 9) < 3);
      s.br     = ($urandom_range(0, 9) == 0);
      s.macc   = ($urandom_range(0, 9) < 3);
      s.dump   = ($urandom_range(0, 32) == 0);
      s.dstall = ($urandom_range(0, 9) < 4);
      s.ddone  = ($urandom_range(0, 9) < 3);
      s.istall = ($urandom_range(0, 4) == 0);
      drive(s);
    end
    drive(idle());

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
